// File: rtl/mcu_sysctrl_gen.sv
// MCU system controller: AHB-Lite slave with boot remap, sticky reset cause, CFG bank and PLL low-power FSM.
// Optional write protection (KEY register at 0x0FC) is enabled by defining MCU_SYSCTRL_WPROT_EN.
module mcu_sysctrl_gen #(
  parameter int          NUM_CFG      = 4,
  parameter logic [31:0] CFG_RESET    = 32'h0000_0000,
  parameter int          LOCK_TIMEOUT = 1023,
  parameter int          CNT_W        = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic                  HREADY,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [11:0]           HADDR,
  input  logic [31:0]           HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  input  logic                  CFG_BOOT,
  input  logic                  SYSRESETREQ,
  input  logic                  WDOGRESETREQ,
  input  logic                  LOCKUP,
  input  logic                  SLEEPREQ,
  output logic                  SLEEPACK,
  input  logic                  PLL_LOCK,
  output logic                  PLL_EN,
  output logic                  REMAP,
  output logic [NUM_CFG*32-1:0] CFG_OUT
);

  // Bus handshake: an address phase is accepted when HSEL & HREADY & HTRANS[1];
  // the slave never stalls, so the following cycle is always the completing data phase.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SLEEP  = 2'd1,
    ST_STOP   = 2'd2,
    ST_RELOCK = 2'd3
  } pwr_state_t;

  localparam logic [CNT_W-1:0] LOCK_T   = CNT_W'(LOCK_TIMEOUT);
  localparam logic [9:0]       CFG_BASE = 10'd4;
  localparam logic [9:0]       CFG_END  = 10'(4 + NUM_CFG);

  logic        d_valid, d_write;
  logic [11:0] d_addr;
  logic [2:0]  d_size;
  logic [9:0]  widx;
  logic [3:0]  lanes;
  logic        wr_en, remap_hit, info_hit, pctl_hit, stat_hit, cfg_hit, prot_ok;
  logic        remap_q, boot_pend, stop_en_q, lock_meta, lock_s;
  logic [3:0]  info_q, info_set, info_clr;
  logic [31:0] cfg_q [NUM_CFG];
  logic [31:0] rdata;
  pwr_state_t  state;
  logic [CNT_W-1:0] cnt;
  logic        sleepack_q, pll_en_q, timeout_hit;
  logic        unused_htrans0;

  assign unused_htrans0 = HTRANS[0];
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      d_valid <= 1'b0;
      d_write <= 1'b0;
      d_addr  <= '0;
      d_size  <= '0;
    end else if (HREADY) begin
      d_valid <= HSEL & HTRANS[1];
      d_write <= HWRITE;
      d_addr  <= HADDR;
      d_size  <= HSIZE;
    end
  end

  always_comb begin
    lanes = 4'b0000;
    case (d_size)
      3'd0:    lanes[d_addr[1:0]] = 1'b1;
      3'd1:    lanes = d_addr[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
  end

  assign widx      = d_addr[11:2];
  assign wr_en     = d_valid & d_write;
  assign remap_hit = (widx == 10'd0);
  assign info_hit  = (widx == 10'd1);
  assign pctl_hit  = (widx == 10'd2);
  assign stat_hit  = (widx == 10'd3);
  assign cfg_hit   = (widx >= CFG_BASE) && (widx < CFG_END);

`ifdef MCU_SYSCTRL_WPROT_EN
  // Window stays open for 16 cycles after the key, or until one protected write lands.
  localparam logic [31:0] KEY = 32'h5A5A_A5A5;
  logic [4:0] win_cnt;
  logic       key_ok, prot_wr;

  assign key_ok  = wr_en && (widx == 10'h03F) && (HWDATA == KEY);
  assign prot_ok = (win_cnt != 5'd0);
  assign prot_wr = wr_en & prot_ok & (remap_hit | pctl_hit | cfg_hit);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)        win_cnt <= 5'd0;
    else if (key_ok)   win_cnt <= 5'd16;
    else if (prot_wr)  win_cnt <= 5'd0;
    else if (prot_ok)  win_cnt <= win_cnt - 5'd1;
  end
`else
  assign prot_ok = 1'b1;
`endif

  // A bus write in the first cycle after reset release overrides the boot-pin load.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      remap_q   <= 1'b0;
      boot_pend <= 1'b1;
      stop_en_q <= 1'b0;
    end else begin
      boot_pend <= 1'b0;
      if (wr_en && remap_hit && lanes[0] && prot_ok) remap_q <= HWDATA[0];
      else if (boot_pend)                           remap_q <= CFG_BOOT;
      if (wr_en && pctl_hit && lanes[0] && prot_ok) stop_en_q <= HWDATA[0];
    end
  end

  assign info_set = {timeout_hit, LOCKUP, WDOGRESETREQ, SYSRESETREQ};
  assign info_clr = (wr_en && info_hit && lanes[0]) ? HWDATA[3:0] : 4'h0;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) info_q <= 4'h0;
    else        info_q <= (info_q & ~info_clr) | info_set;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= CFG_RESET;
    end else if (wr_en && prot_ok) begin
      for (int i = 0; i < NUM_CFG; i++) begin
        if (widx == 10'(4 + i)) begin
          for (int b = 0; b < 4; b++) begin
            if (lanes[b]) cfg_q[i][8*b +: 8] <= HWDATA[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CFG; i++) CFG_OUT[32*i +: 32] = cfg_q[i];
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= PLL_LOCK;
      lock_s    <= lock_meta;
    end
  end

  // Lock seen in the same cycle as the timeout takes priority, so no flag is raised.
  assign timeout_hit = (state == ST_RELOCK) && !lock_s && (cnt == LOCK_T);

  // Outputs are registered from the current state, lagging each transition by one cycle.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state      <= ST_RUN;
      cnt        <= '0;
      sleepack_q <= 1'b0;
      pll_en_q   <= 1'b1;
    end else begin
      sleepack_q <= (state != ST_RUN);
      pll_en_q   <= (state != ST_STOP);
      case (state)
        ST_RUN:    if (SLEEPREQ) state <= stop_en_q ? ST_STOP : ST_SLEEP;
        ST_SLEEP:  if (!SLEEPREQ) state <= ST_RUN;
        ST_STOP: begin
          if (!SLEEPREQ) begin
            state <= ST_RELOCK;
            cnt   <= '0;
          end
        end
        ST_RELOCK: begin
          if (lock_s || cnt == LOCK_T) state <= ST_RUN;
          else                         cnt   <= cnt + 1'b1;
        end
        default:   state <= ST_RUN;
      endcase
    end
  end

  assign SLEEPACK = sleepack_q;
  assign PLL_EN   = pll_en_q;
  assign REMAP    = remap_q;

  always_comb begin
    rdata = 32'h0;
    if (d_valid && !d_write) begin
      if (remap_hit) rdata[0] = remap_q;
      if (info_hit)  rdata[3:0] = info_q;
      if (pctl_hit)  rdata[0] = stop_en_q;
      if (stat_hit) begin
        rdata[1:0]          = state;
        rdata[2]            = lock_s;
        rdata[16 +: CNT_W]  = cnt;
      end
      for (int i = 0; i < NUM_CFG; i++) begin
        if (widx == 10'(4 + i)) rdata = cfg_q[i];
      end
    end
  end

  assign HRDATA = rdata;

endmodule

// File: tb/tb_mcu_sysctrl_gen.sv
// Self-checking bench for mcu_sysctrl_gen: directed plan items plus randomized bus and low-power traffic.
module tb_mcu_sysctrl_gen;

  localparam int          NCFG  = 4;
  localparam logic [31:0] CRST  = 32'h1357_9BDF;
  localparam int          LTO   = 20;

  logic HCLK, HRESET, HSEL, HREADY, HWRITE, HREADYOUT, HRESP;
  logic [1:0] HTRANS;
  logic [2:0] HSIZE;
  logic [11:0] HADDR;
  logic [31:0] HWDATA, HRDATA;
  logic CFG_BOOT, SYSRESETREQ, WDOGRESETREQ, LOCKUP, SLEEPREQ, SLEEPACK, PLL_LOCK, PLL_EN, REMAP;
  logic [NCFG*32-1:0] CFG_OUT;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_cfg [NCFG];
  logic [31:0] exp_q [$];

  mcu_sysctrl_gen #(.NUM_CFG(NCFG), .CFG_RESET(CRST), .LOCK_TIMEOUT(LTO), .CNT_W(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .HRDATA(HRDATA), .CFG_BOOT(CFG_BOOT), .SYSRESETREQ(SYSRESETREQ), .WDOGRESETREQ(WDOGRESETREQ),
    .LOCKUP(LOCKUP), .SLEEPREQ(SLEEPREQ), .SLEEPACK(SLEEPACK), .PLL_LOCK(PLL_LOCK), .PLL_EN(PLL_EN),
    .REMAP(REMAP), .CFG_OUT(CFG_OUT)
  );

  // Clock and reset
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past time limit");
    $fatal(1, "time limit");
  end

  // Reference model: byte-lane merge from the transfer size rules
  function automatic logic [31:0] merge(logic [31:0] old, logic [1:0] a, logic [2:0] sz, logic [31:0] d);
    logic [31:0] r;
    bit en;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (sz == 3'd0)      en = (b == int'(a));
      else if (sz == 3'd1) en = ((b / 2) == int'(a[1]));
      else                 en = 1'b1;
      if (en) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [NCFG*32-1:0] cfg_cat();
    logic [NCFG*32-1:0] r;
    for (int i = 0; i < NCFG; i++) r[32*i +: 32] = m_cfg[i];
    return r;
  endfunction

  // Driver tasks
  task automatic bus_write(input logic [11:0] a, input logic [2:0] sz, input logic [31:0] d, input logic [2:0] pulse);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a; HSIZE = sz;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    {LOCKUP, WDOGRESETREQ, SYSRESETREQ} = pulse;
    @(negedge HCLK);
    {LOCKUP, WDOGRESETREQ, SYSRESETREQ} = 3'b000;
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a; HSIZE = 3'd2;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    HRESET = 1'b1; CFG_BOOT = 1'b1;
    repeat (3) @(negedge HCLK);
    n_cmp++; if (REMAP !== 1'b0) begin n_err++; $display("FAIL rst_remap: got %b want 0", REMAP); end
    n_cmp++; if (SLEEPACK !== 1'b0) begin n_err++; $display("FAIL rst_sleepack: got %b want 0", SLEEPACK); end
    n_cmp++; if (PLL_EN !== 1'b1) begin n_err++; $display("FAIL rst_pll_en: got %b want 1", PLL_EN); end
    n_cmp++; if (HRDATA !== 32'h0) begin n_err++; $display("FAIL rst_hrdata: got %h want 0", HRDATA); end
    n_cmp++; if ({HREADYOUT, HRESP} !== 2'b10) begin n_err++; $display("FAIL rst_resp: got %b want 10", {HREADYOUT, HRESP}); end
    n_cmp++; if (CFG_OUT !== cfg_cat()) begin n_err++; $display("FAIL rst_cfg: got %h want %h", CFG_OUT, cfg_cat()); end
    HRESET = 1'b0;
    @(negedge HCLK);
    CFG_BOOT = 1'b0;
    n_cmp++; if (REMAP !== 1'b1) begin n_err++; $display("FAIL boot_remap: got %b want 1", REMAP); end
    bus_read(12'h004, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rst_resetinfo: got %h want 0", rd); end
    bus_read(12'h008, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rst_pwrctrl: got %h want 0", rd); end
    bus_read(12'h00C, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rst_pwrstat: got %h want 0", rd); end
    bus_write(12'h000, 3'd2, 32'h0, 3'b000);
    n_cmp++; if (REMAP !== 1'b0) begin n_err++; $display("FAIL remap_wr0: got %b want 0", REMAP); end
    bus_read(12'h000, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL remap_rd0: got %h want 0", rd); end
    bus_write(12'h000, 3'd2, 32'h1, 3'b000);
    bus_write(12'h001, 3'd0, 32'h0, 3'b000);
    n_cmp++; if (REMAP !== 1'b1) begin n_err++; $display("FAIL remap_lane1_ignored: got %b want 1", REMAP); end
  endtask

  task automatic test_cfg();
    logic [11:0] a;
    logic [2:0]  sz;
    logic [31:0] d, rd, ex;
    int idx;
    bus_write(12'h010, 3'd2, 32'h0, 3'b000);
    m_cfg[0] = merge(m_cfg[0], 2'd0, 3'd2, 32'h0);
    bus_write(12'h011, 3'd0, 32'h0000_AB00, 3'b000);
    m_cfg[0] = merge(m_cfg[0], 2'd1, 3'd0, 32'h0000_AB00);
    bus_write(12'h012, 3'd1, 32'h1234_0000, 3'b000);
    m_cfg[0] = merge(m_cfg[0], 2'd2, 3'd1, 32'h1234_0000);
    n_cmp++; if (CFG_OUT[31:0] !== 32'h1234_AB00) begin n_err++; $display("FAIL cfg0_bytes: got %h want 1234ab00", CFG_OUT[31:0]); end
    n_cmp++; if (CFG_OUT !== cfg_cat()) begin n_err++; $display("FAIL cfg_others: got %h want %h", CFG_OUT, cfg_cat()); end
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) != 0) a = 12'h010 + 12'($urandom_range(0, 15));
      else                           a = 12'h020 + 12'($urandom_range(0, 12'hFDF));
      sz = 3'($urandom_range(0, 2));
      if (sz == 3'd1) a[0] = 1'b0;
      if (sz == 3'd2) a[1:0] = 2'b00;
      d = $urandom;
      bus_write(a, sz, d, 3'b000);
      if (a < 12'h020) begin
        idx = (int'(a) - 16) / 4;
        m_cfg[idx] = merge(m_cfg[idx], a[1:0], sz, d);
      end
      n_cmp++; if (CFG_OUT !== cfg_cat()) begin n_err++; $display("FAIL cfg_rand a=%h sz=%0d: got %h want %h", a, sz, CFG_OUT, cfg_cat()); end
    end
    for (int i = 0; i < NCFG + 3; i++) begin
      if (i < NCFG) begin a = 12'h010 + 12'(4 * i); exp_q.push_back(m_cfg[i]); end
      else begin a = 12'h020 + {2'b00, 10'($urandom_range(0, 1015)) & 10'h3FC}; exp_q.push_back(32'h0); end
      bus_read(a, rd);
      ex = exp_q.pop_front();
      n_cmp++; if (rd !== ex) begin n_err++; $display("FAIL cfg_read a=%h: got %h want %h", a, rd, ex); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, old;
    d = $urandom;
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 12'h014; HSIZE = 3'd2;
    @(negedge HCLK);
    HWRITE = 1'b0; HWDATA = d;
    m_cfg[1] = merge(m_cfg[1], 2'd0, 3'd2, d);
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    n_cmp++; if (HRDATA !== m_cfg[1]) begin n_err++; $display("FAIL b2b_wr_rd: got %h want %h", HRDATA, m_cfg[1]); end
    old = m_cfg[2];
    d = $urandom;
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 12'h018;
    @(negedge HCLK);
    HWRITE = 1'b1;
    n_cmp++; if (HRDATA !== old) begin n_err++; $display("FAIL b2b_rd_wr: got %h want %h", HRDATA, old); end
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    m_cfg[2] = merge(m_cfg[2], 2'd0, 3'd2, d);
    @(negedge HCLK);
    n_cmp++; if (CFG_OUT !== cfg_cat()) begin n_err++; $display("FAIL b2b_cfg: got %h want %h", CFG_OUT, cfg_cat()); end
  endtask

  task automatic test_resetinfo();
    logic [31:0] rd;
    logic [3:0] m, clr;
    logic [2:0] p;
    @(negedge HCLK);
    WDOGRESETREQ = 1'b1; LOCKUP = 1'b1;
    @(negedge HCLK);
    WDOGRESETREQ = 1'b0; LOCKUP = 1'b0;
    bus_read(12'h004, rd);
    n_cmp++; if (rd !== 32'h6) begin n_err++; $display("FAIL info_set: got %h want 6", rd); end
    bus_write(12'h004, 3'd2, 32'h2, 3'b000);
    bus_read(12'h004, rd);
    n_cmp++; if (rd !== 32'h4) begin n_err++; $display("FAIL info_w1c: got %h want 4", rd); end
    bus_write(12'h004, 3'd2, 32'h4, 3'b100);
    bus_read(12'h004, rd);
    n_cmp++; if (rd !== 32'h4) begin n_err++; $display("FAIL info_set_wins: got %h want 4", rd); end
    bus_write(12'h005, 3'd0, 32'h0000_FF00, 3'b000);
    bus_read(12'h004, rd);
    n_cmp++; if (rd !== 32'h4) begin n_err++; $display("FAIL info_lane1_ignored: got %h want 4", rd); end
    m = 4'h4;
    for (int k = 0; k < 20; k++) begin
      p = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) p = 3'b000;
      clr = 4'($urandom_range(0, 15));
      bus_write(12'h004, 3'd2, {28'h0, clr}, p);
      m = (m & ~clr) | {1'b0, p};
      bus_read(12'h004, rd);
      n_cmp++; if (rd !== {28'h0, m}) begin n_err++; $display("FAIL info_rand clr=%h set=%b: got %h want %h", clr, p, rd, m); end
    end
    bus_write(12'h004, 3'd2, 32'hF, 3'b000);
  endtask

  task automatic test_lowpower();
    logic [31:0] rd;
    int dl [8];
    int d, n, ex_exit;
    bit done, ex_flag;
    dl[0] = 5; dl[1] = LTO - 1; dl[2] = LTO; dl[3] = 0; dl[4] = 30;
    for (int i = 5; i < 8; i++) dl[i] = $urandom_range(0, 30);
    bus_write(12'h008, 3'd2, 32'h1, 3'b000);
    bus_read(12'h008, rd);
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL pwrctrl_rd: got %h want 1", rd); end
    for (int it = 0; it < 8; it++) begin
      d = dl[it];
      @(negedge HCLK);
      SLEEPREQ = 1'b1; PLL_LOCK = 1'b0;
      repeat (2) @(negedge HCLK);
      bus_read(12'h00C, rd);
      n_cmp++; if (rd[1:0] !== 2'd2) begin n_err++; $display("FAIL stop_state: got %0d want 2", rd[1:0]); end
      n_cmp++; if ({PLL_EN, SLEEPACK} !== 2'b01) begin n_err++; $display("FAIL stop_outs: got pll_en/ack=%b want 01", {PLL_EN, SLEEPACK}); end
      SLEEPREQ = 1'b0;
      if (d == 0) PLL_LOCK = 1'b1;
      n = 0; done = 1'b0;
      while (!done && n < 100) begin
        @(negedge HCLK);
        n++;
        if (n == d) PLL_LOCK = 1'b1;
        if (SLEEPACK === 1'b0) done = 1'b1;
      end
      ex_exit = (d + 3 <= LTO + 2) ? d + 3 : LTO + 2;
      ex_flag = (d + 3 > LTO + 2);
      n_cmp++; if (n != ex_exit + 1) begin n_err++; $display("FAIL relock_exit d=%0d: got %0d cycles want %0d", d, n, ex_exit + 1); end
      n_cmp++; if (PLL_EN !== 1'b1) begin n_err++; $display("FAIL relock_pll_en d=%0d: got %b want 1", d, PLL_EN); end
      bus_read(12'h004, rd);
      n_cmp++; if (rd[3] !== ex_flag) begin n_err++; $display("FAIL relock_flag d=%0d: got %b want %b", d, rd[3], ex_flag); end
      bus_read(12'h00C, rd);
      n_cmp++; if (rd[1:0] !== 2'd0) begin n_err++; $display("FAIL relock_run d=%0d: got %0d want 0", d, rd[1:0]); end
      bus_write(12'h004, 3'd2, 32'h8, 3'b000);
      PLL_LOCK = 1'b0;
    end
  endtask

  task automatic test_sleep_reset();
    logic [31:0] rd;
    bus_write(12'h008, 3'd2, 32'h0, 3'b000);
    @(negedge HCLK);
    SLEEPREQ = 1'b1;
    repeat (3) @(negedge HCLK);
    n_cmp++; if ({PLL_EN, SLEEPACK} !== 2'b11) begin n_err++; $display("FAIL sleep_outs: got pll_en/ack=%b want 11", {PLL_EN, SLEEPACK}); end
    bus_read(12'h00C, rd);
    n_cmp++; if (rd[1:0] !== 2'd1) begin n_err++; $display("FAIL sleep_state: got %0d want 1", rd[1:0]); end
    #2 HRESET = 1'b1;
    #1;
    n_cmp++; if ({PLL_EN, SLEEPACK, REMAP} !== 3'b100) begin n_err++; $display("FAIL async_rst_outs: got %b want 100", {PLL_EN, SLEEPACK, REMAP}); end
    n_cmp++; if (HRDATA !== 32'h0) begin n_err++; $display("FAIL async_rst_hrdata: got %h want 0", HRDATA); end
    for (int i = 0; i < NCFG; i++) m_cfg[i] = CRST;
    n_cmp++; if (CFG_OUT !== cfg_cat()) begin n_err++; $display("FAIL async_rst_cfg: got %h want %h", CFG_OUT, cfg_cat()); end
    SLEEPREQ = 1'b0;
    @(negedge HCLK);
    HRESET = 1'b0;
    bus_read(12'h00C, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL post_rst_pwrstat: got %h want 0", rd); end
  endtask

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HREADY = 1'b1; HTRANS = 2'b00; HSIZE = 3'd0; HWRITE = 1'b0;
    HADDR = 12'h0; HWDATA = 32'h0; CFG_BOOT = 1'b0; SYSRESETREQ = 1'b0; WDOGRESETREQ = 1'b0;
    LOCKUP = 1'b0; SLEEPREQ = 1'b0; PLL_LOCK = 1'b0;
    for (int i = 0; i < NCFG; i++) m_cfg[i] = CRST;
    test_reset();
    test_cfg();
    test_back_to_back();
    test_resetinfo();
    test_lowpower();
    test_sleep_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
